// File: rtl/inv_mix_columns_seq.sv
// AES InvMixColumns stage: captures a 128-bit state over valid/ready, transforms
// COLS_PER_CYCLE columns per clock, then holds the result until downstream accepts it.
module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         i_abort,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_state,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_state
);

  // Handshake: a state is accepted at an edge where i_valid && o_ready; a result
  // is consumed at an edge where o_valid && i_ready; i_abort overrides both.

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiplies by 09/0B/0D/0E built from the x2, x4, x8 xtime chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m09[4];
    logic [7:0] m0b[4];
    logic [7:0] m0d[4];
    logic [7:0] m0e[4];
    logic [31:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      a[r]   = col[31-8*r -: 8];
      x2[r]  = xtime(a[r]);
      x4[r]  = xtime(x2[r]);
      x8[r]  = xtime(x4[r]);
      m09[r] = x8[r] ^ a[r];
      m0b[r] = x8[r] ^ x2[r] ^ a[r];
      m0d[r] = x8[r] ^ x4[r] ^ a[r];
      m0e[r] = x8[r] ^ x4[r] ^ x2[r];
    end
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = m0e[r] ^ m0b[(r+1)%4] ^ m0d[(r+2)%4] ^ m09[(r+3)%4];
    end
    return res;
  endfunction

  logic [1:0]   state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] cap_q, cap_d;
  logic [127:0] res_q, res_d;
  logic [1:0]   idx;
  logic [1:0]   slot;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cap_d   = cap_q;
    res_d   = res_q;
    idx     = '0;
    slot    = '0;
    if (i_abort) begin
      state_d = ST_IDLE;
      col_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            cap_d   = i_state;
            col_d   = '0;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Column c lives at bits [127-32c -: 32], i.e. slot (3-c) counting from the LSB.
          for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            idx  = col_q + 2'(k);
            slot = ~idx;
            res_d[{slot, 5'd0} +: 32] = inv_mix_col(cap_q[{slot, 5'd0} +: 32]);
          end
          col_d = col_q + COL_STEP;
          if (col_q == LAST_COL) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      cap_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cap_q   <= cap_d;
      res_q   <= res_d;
    end
  end

  assign o_ready = (state_q == ST_IDLE);
  assign o_valid = (state_q == ST_DONE);
  assign o_state = res_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: table vectors, handshake corner sequences and
// random states checked against a GF(2^8) matrix model.
module tb_inv_mix_columns_seq;

  localparam int CPC = 1;
  localparam int LAT = 4 / CPC;

  logic         clk;
  logic         n_rst;
  logic         i_abort;
  logic         i_valid;
  logic         o_ready;
  logic [127:0] i_state;
  logic         o_valid;
  logic         i_ready;
  logic [127:0] o_state;

  int n_checks;
  int n_fail;

  typedef struct {
    string        name;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t vecs[3];

  inv_mix_columns_seq #(.COLS_PER_CYCLE(CPC)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_abort (i_abort),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_state (i_state),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_state (o_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: generic GF(2^8) product and the circulant {0E,0B,0D,09} matrix.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [7:0] coef[4];
    logic [7:0] a[4];
    logic [7:0] b;
    logic [127:0] res;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127 - 32*c - 8*r -: 8];
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gf_mul(coef[(j - r + 4) % 4], a[j]);
        res[127 - 32*c - 8*r -: 8] = b;
      end
    end
    return res;
  endfunction

  // Scoreboard
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Driver tasks
  task automatic wait_ready();
    int t;
    t = 0;
    while (!o_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", 128'(o_ready), 128'(1));
  endtask

  task automatic start_and_wait(input logic [127:0] din, input logic [127:0] exp,
                                input string name, input bit disturb);
    int lat;
    wait_ready();
    i_state = din;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = disturb;
    if (disturb) i_state = rand_state();
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (disturb) i_state = rand_state();
    end
    i_valid = 1'b0;
    check({name, "_latency"}, 128'(lat), 128'(LAT));
    check({name, "_result"}, o_state, exp);
    check({name, "_busy_ready"}, 128'(o_ready), 128'(0));
  endtask

  task automatic run_txn(input logic [127:0] din, input logic [127:0] exp,
                         input string name, input int hold, input bit disturb);
    start_and_wait(din, exp, name, disturb);
    for (int h = 0; h < hold; h++) begin
      i_valid = 1'b1;
      i_state = rand_state();
      @(negedge clk);
      check({name, "_hold_valid"}, 128'(o_valid), 128'(1));
      check({name, "_hold_state"}, o_state, exp);
      check({name, "_hold_ready"}, 128'(o_ready), 128'(0));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check({name, "_release_valid"}, 128'(o_valid), 128'(0));
    check({name, "_release_ready"}, 128'(o_ready), 128'(1));
    check({name, "_release_keep"}, o_state, exp);
  endtask

  initial begin
    logic [127:0] r;
    n_checks = 0;
    n_fail   = 0;
    n_rst    = 1'b0;
    i_abort  = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_state  = '0;

    vecs[0] = '{"all_cols", {4{32'h8e4da1bc}}, {4{32'hdb135345}}};
    vecs[1] = '{"mixed", {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6},
                         {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5}};
    vecs[2] = '{"fresh", {4{32'h4d7ebdf8}}, {4{32'h2d26314c}}};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 128'(o_valid), 128'(0));
    check("rst_state", o_state, 128'(0));
    n_rst = 1'b1;
    @(negedge clk);
    check("rst_ready", 128'(o_ready), 128'(1));

    // Table vectors
    for (int v = 0; v < 3; v++) run_txn(vecs[v].din, vecs[v].dout, vecs[v].name, 0, 1'b0);

    // Backpressure for 10 cycles in DONE with new i_valid ignored
    run_txn(vecs[1].din, vecs[1].dout, "backpressure", 10, 1'b0);

    // Input changes while BUSY do not affect the captured state
    run_txn(vecs[0].din, vecs[0].dout, "busy_change", 0, 1'b1);

    // Abort while BUSY
    wait_ready();
    i_state = vecs[1].din;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("abort_ready", 128'(o_ready), 128'(1));
    check("abort_valid", 128'(o_valid), 128'(0));
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      check("abort_no_valid", 128'(o_valid), 128'(0));
    end

    // Abort wins over a simultaneous accept
    i_state = vecs[0].din;
    i_valid = 1'b1;
    i_abort = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    i_abort = 1'b0;
    check("abort_vs_accept", 128'(o_ready), 128'(1));

    // Abort wins over i_ready in DONE
    start_and_wait(vecs[0].din, vecs[0].dout, "abort_done", 1'b0);
    i_abort = 1'b1;
    i_ready = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    i_ready = 1'b0;
    check("abort_done_valid", 128'(o_valid), 128'(0));
    check("abort_done_keep", o_state, vecs[0].dout);

    // Reset asserted while in DONE
    start_and_wait(vecs[1].din, vecs[1].dout, "rst_done", 1'b0);
    n_rst = 1'b0;
    #1;
    check("rst_done_valid", 128'(o_valid), 128'(0));
    check("rst_done_state", o_state, 128'(0));
    @(negedge clk);
    n_rst = 1'b1;
    run_txn(vecs[2].din, vecs[2].dout, "post_rst", 0, 1'b0);

    // Random states against the model
    for (int n = 0; n < 24; n++) begin
      r = rand_state();
      run_txn(r, model(r), "random", $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
